// File: rtl/alu_pkg.sv
// Shared opcode, state and flag helpers for seq_alu and its control unit.
// The MUL state encoding only exists when SEQ_ALU_MUL_EN is defined.
package alu_pkg;

  localparam int OPW = 4;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'b00;
`ifdef SEQ_ALU_MUL_EN
  localparam state_t ST_MUL  = 2'b01;
`endif
  localparam state_t ST_DONE = 2'b10;

  // Signed overflow from sign bits; SUB passes the inverted B sign.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low WIDTH bits kept.
// done pulses for one cycle after WIDTH iterations; busy covers load through done.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] acc_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             last_s;

  assign last_s = (cnt_r == CW'(WIDTH));

  // Operand load on start, then one add/shift step per cycle until the count is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      busy_r   <= 1'b0;
    end else if (start) begin
      mcand_r  <= a;
      mplier_r <= b;
      acc_r    <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      busy_r   <= 1'b1;
    end else if (busy_r) begin
      if (last_s) begin
        busy_r <= 1'b0;
      end else begin
        acc_r    <= acc_r + (mplier_r[0] ? mcand_r : {WIDTH{1'b0}});
        mcand_r  <= mcand_r << 1;
        mplier_r <= mplier_r >> 1;
        cnt_r    <= cnt_r + CW'(1);
      end
    end
  end

  assign busy = busy_r;
  assign done = busy_r & last_s;
  assign p    = acc_r;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes on both sides and a registered result.
// Define SEQ_ALU_MUL_EN to build in the iterative multiplier and its MUL state.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int OPW   = alu_pkg::OPW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  import alu_pkg::*;

  localparam int SHW = $clog2(WIDTH);

  state_t           state_r;
  state_t           state_nx_s;
  state_t           launch_st_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             load_alu_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] alu_r_s;
  logic             alu_ovf_s;
  logic             alu_err_s;
  logic [WIDTH-1:0] r_r;
  logic             zero_r;
  logic             ovf_r;
  logic             err_r;

  assign in_ready_s = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready);
  assign accept_s   = in_valid && in_ready_s;
  assign sum_s      = a + b;
  assign diff_s     = a - b;

`ifdef SEQ_ALU_MUL_EN
  logic             is_mul_s;
  logic             mul_busy_s;
  logic             mul_done_s;
  logic [WIDTH-1:0] mul_p_s;

  assign is_mul_s    = (op == OPW'(OP_MUL));
  assign launch_st_s = is_mul_s ? ST_MUL : ST_DONE;
  assign load_alu_s  = accept_s && !is_mul_s;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (accept_s && is_mul_s),
    .a     (a),
    .b     (b),
    .busy  (mul_busy_s),
    .done  (mul_done_s),
    .p     (mul_p_s)
  );
`else
  assign launch_st_s = ST_DONE;
  assign load_alu_s  = accept_s;
`endif

  // Single-cycle operation decode; anything not listed completes as an error with r=0.
  always_comb begin
    alu_r_s   = {WIDTH{1'b0}};
    alu_ovf_s = 1'b0;
    alu_err_s = 1'b0;
    case (op)
      OPW'(OP_AND):  alu_r_s = a & b;
      OPW'(OP_OR):   alu_r_s = a | b;
      OPW'(OP_ADD): begin
        alu_r_s   = sum_s;
        alu_ovf_s = add_ovf(a[WIDTH-1], b[WIDTH-1], sum_s[WIDTH-1]);
      end
      OPW'(OP_SUB): begin
        alu_r_s   = diff_s;
        alu_ovf_s = add_ovf(a[WIDTH-1], ~b[WIDTH-1], diff_s[WIDTH-1]);
      end
      OPW'(OP_SLTU): alu_r_s = {{(WIDTH-1){1'b0}}, (a < b)};
      OPW'(OP_SLT):  alu_r_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OPW'(OP_SLL):  alu_r_s = a << b[SHW-1:0];
      OPW'(OP_SRL):  alu_r_s = a >> b[SHW-1:0];
      OPW'(OP_NOR):  alu_r_s = ~(a | b);
`ifdef SEQ_ALU_MUL_EN
      OPW'(OP_MUL):  alu_r_s = {WIDTH{1'b0}};
`endif
      default:       alu_err_s = 1'b1;
    endcase
  end

  // Next-state logic; a MUL that loses its multiplier falls back to IDLE.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nx_s = launch_st_s;
        else          state_nx_s = ST_IDLE;
      end
`ifdef SEQ_ALU_MUL_EN
      ST_MUL: begin
        if (mul_done_s)      state_nx_s = ST_DONE;
        else if (mul_busy_s) state_nx_s = ST_MUL;
        else                 state_nx_s = ST_IDLE;
      end
`endif
      ST_DONE: begin
        if (!out_ready)    state_nx_s = ST_DONE;
        else if (accept_s) state_nx_s = launch_st_s;
        else               state_nx_s = ST_IDLE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State and result registers; result fields change only when a new result is produced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      r_r     <= {WIDTH{1'b0}};
      zero_r  <= 1'b1;
      ovf_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if (load_alu_s) begin
        r_r    <= alu_r_s;
        zero_r <= (alu_r_s == {WIDTH{1'b0}});
        ovf_r  <= alu_ovf_s;
        err_r  <= alu_err_s;
      end
`ifdef SEQ_ALU_MUL_EN
      else if (mul_done_s && (state_r == ST_MUL)) begin
        r_r    <= mul_p_s;
        zero_r <= (mul_p_s == {WIDTH{1'b0}});
        ovf_r  <= 1'b0;
        err_r  <= 1'b0;
      end
`endif
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = (state_r == ST_DONE);
  assign r         = r_r;
  assign zero      = zero_r;
  assign ovf       = ovf_r;
  assign err       = err_r;

endmodule
